// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared W-bit register (q/qbar).
// Define ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD consecutive owned cycles.
module shared_reg_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N-1:0]                      req,
    input  logic [N-1:0]                      wr_en,
    input  logic [N*W-1:0]                    wr_data,
    output logic [N-1:0]                      gnt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] owner_id,
    output logic                              busy,
    output logic                              expired,
    output logic [W-1:0]                      q,
    output logic [W-1:0]                      qbar
);

    localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1;

    if (N < 2 || N > 16 || MAX_HOLD < 1) begin : g_bad_param
        $error("shared_reg_arbiter: N must be 2..16 and MAX_HOLD >= 1");
    end

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IdW-1:0] owner_q, owner_d;
    logic [IdW-1:0] last_q, last_d;
    logic [W-1:0]   q_q, q_d;

    logic [IdW-1:0] winner;
    logic           found;
    int unsigned    rr_idx;

    // Search starts just after the last winner and wraps, giving round-robin fairness.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        rr_idx = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            rr_idx = (int'(last_q) + k) % N;
            if (!found && req[rr_idx]) begin
                found  = 1'b1;
                winner = IdW'(rr_idx);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          expired_q, expired_d;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        q_d     = q_q;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        expired_d  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StOwn;
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << winner;
                    owner_d = winner;
                    last_d  = winner;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            StOwn: begin
                if (!req[owner_q]) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                end else begin
                    if (wr_en[owner_q]) begin
                        q_d = wr_data[owner_q*W +: W];
                    end
`ifdef ARB_TIMEOUT_EN
                    // The write on the final edge still lands before the grant is revoked.
                    if (hold_cnt_q == HW'(MAX_HOLD - 1)) begin
                        state_d   = StIdle;
                        gnt_d     = '0;
                        expired_d = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= IdW'(N - 1);
            q_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            expired_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            q_q     <= q_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            expired_q  <= expired_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign owner_id = owner_q;
    assign busy     = (state_q == StOwn);
    assign q        = q_q;
    assign qbar     = ~q_q;
`ifdef ARB_TIMEOUT_EN
    assign expired  = expired_q;
`else
    assign expired  = 1'b0;
`endif

endmodule
